// File: rtl/seq_add_sub_if.sv
// Operand/result bundle for seq_add_sub: start/busy/done handshake plus data and flags.
interface seq_add_sub_if #(
  parameter int unsigned N = 16
) ();
  logic         start;
  logic         sub;
  logic         carryin;
  logic [N-1:0] Xin;
  logic [N-1:0] Yin;
  logic         busy;
  logic         done;
  logic [N-1:0] S;
  logic         carryout;
  logic         overflow;
  logic         zero;

  modport master (
    output start, sub, carryin, Xin, Yin,
    input  busy, done, S, carryout, overflow, zero
  );

  modport slave (
    input  start, sub, carryin, Xin, Yin,
    output busy, done, S, carryout, overflow, zero
  );
endinterface

// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: adds K bits per clock, LS chunk first, with start/busy/done
// handshake and carry/overflow/zero flags registered together with the result.
module seq_add_sub #(
  parameter int unsigned N = 16,
  parameter int unsigned K = 4
) (
  input logic          clk,
  input logic          reset,
  seq_add_sub_if.slave bus
);
  localparam int unsigned CHUNKS = N / K;
  localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  y_q, y_d;
  logic [N-1:0]  p_q, p_d;
  logic          c_q, c_d;
  logic [CW-1:0] j_q, j_d;
  logic [N-1:0]  s_q, s_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;

  logic [K:0]    sum;
  logic [N-1:0]  p_shift;
  logic          last;

  // Operands shift right each cycle, so the active chunk always sits in the low K bits.
  assign sum  = {1'b0, x_q[K-1:0]} + {1'b0, y_q[K-1:0]} + {{K{1'b0}}, c_q};
  assign last = (j_q == CW'(CHUNKS - 1));

  // Partial sum fills from the top; after CHUNKS steps every chunk is in place.
  if (K == N) begin : g_single
    assign p_shift = sum[K-1:0];
  end else begin : g_multi
    assign p_shift = {sum[K-1:0], p_q[N-1:K]};
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    p_d     = p_q;
    c_d     = c_q;
    j_d     = j_q;
    s_d     = s_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          state_d = StRun;
          x_d     = bus.Xin;
          y_d     = bus.sub ? ~bus.Yin : bus.Yin;
          c_d     = bus.sub | bus.carryin;
          j_d     = '0;
        end
      end
      StRun: begin
        x_d = x_q >> K;
        y_d = y_q >> K;
        p_d = p_shift;
        c_d = sum[K];
        j_d = j_q + CW'(1);
        if (last) begin
          state_d = StDone;
          j_d     = '0;
          s_d     = p_shift;
          carry_d = sum[K];
          // Low bits of the last chunk are the operand sign bits.
          ovf_d   = (x_q[K-1] == y_q[K-1]) && (sum[K-1] != x_q[K-1]);
          zero_d  = (p_shift == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
      c_q     <= 1'b0;
      j_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      c_q     <= c_d;
      j_q     <= j_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy     = (state_q == StRun);
  assign bus.done     = (state_q == StDone);
  assign bus.S        = s_q;
  assign bus.carryout = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
endmodule

// File: tb/tb_seq_add_sub.sv
// Directed and randomized checks of seq_add_sub at (N,K) = (16,4), (8,8) and (32,8).
module tb_seq_add_sub;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seq_add_sub_if #(.N(16)) b16 ();
  seq_add_sub_if #(.N(8))  b8 ();
  seq_add_sub_if #(.N(32)) b32 ();

  seq_add_sub #(.N(16), .K(4)) u16 (.clk(clk), .reset(reset), .bus(b16.slave));
  seq_add_sub #(.N(8),  .K(8)) u8  (.clk(clk), .reset(reset), .bus(b8.slave));
  seq_add_sub #(.N(32), .K(8)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input logic [15:0] x, input logic [15:0] y, input logic sb,
                         input logic ci, input logic st);
    b16.Xin = x; b16.Yin = y; b16.sub = sb; b16.carryin = ci; b16.start = st;
  endtask

  // Counts edges until done (bounded) and the cycles busy was seen high.
  task automatic wait16(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (b16.done !== 1'b1 && lat < 20) begin
      if (b16.busy === 1'b1) busy_cnt++;
      tick;
      lat++;
    end
  endtask

  task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic sb,
                       input logic ci, output int lat, output int busy_cnt);
    drive16(x, y, sb, ci, 1'b1);
    tick;
    b16.start = 1'b0;
    wait16(lat, busy_cnt);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive16(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    b8.start = 1'b0; b8.sub = 1'b0; b8.carryin = 1'b0; b8.Xin = '0; b8.Yin = '0;
    b32.start = 1'b0; b32.sub = 1'b0; b32.carryin = 1'b0; b32.Xin = '0; b32.Yin = '0;
    tick;
    tick;
    tests++;
    if ({b16.busy, b16.done, b16.S, b16.carryout, b16.overflow, b16.zero} !== 21'h0) begin
      fails++;
      $display("FAIL reset16: busy=%b done=%b S=%h c=%b v=%b z=%b, want all 0",
               b16.busy, b16.done, b16.S, b16.carryout, b16.overflow, b16.zero);
    end
    tests++;
    if ({b8.busy, b8.done, b8.S, b8.carryout, b8.overflow, b8.zero} !== 13'h0) begin
      fails++;
      $display("FAIL reset8: S=%h busy=%b done=%b, want all 0", b8.S, b8.busy, b8.done);
    end
    tests++;
    if ({b32.busy, b32.done, b32.S, b32.carryout, b32.overflow, b32.zero} !== 37'h0) begin
      fails++;
      $display("FAIL reset32: S=%h busy=%b done=%b, want all 0", b32.S, b32.busy, b32.done);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_add;
    int lat, bc;
    run16(16'h1234, 16'h0FCC, 1'b0, 1'b0, lat, bc);
    tests++;
    if (lat != 4) begin
      fails++;
      $display("FAIL add_latency: got %0d cycles, want 4", lat);
    end
    tests++;
    if (bc != 4) begin
      fails++;
      $display("FAIL add_busy_cycles: got %0d, want 4", bc);
    end
    tests++;
    if (b16.busy !== 1'b0) begin
      fails++;
      $display("FAIL add_busy_in_done: got %b, want 0", b16.busy);
    end
    tests++;
    if ({b16.S, b16.carryout, b16.overflow, b16.zero} !== {16'h2200, 3'b000}) begin
      fails++;
      $display("FAIL add_result: got S=%h c=%b v=%b z=%b, want S=2200 c=0 v=0 z=0",
               b16.S, b16.carryout, b16.overflow, b16.zero);
    end
    tick;
    tests++;
    if (b16.done !== 1'b0 || b16.S !== 16'h2200) begin
      fails++;
      $display("FAIL add_done_pulse: got done=%b S=%h, want done=0 S=2200", b16.done, b16.S);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] xs[3] = '{16'hFFFF, 16'hFFFF, 16'h7FFF};
    logic [15:0] ys[3] = '{16'h0001, 16'h0000, 16'h0001};
    logic        cs[3] = '{1'b0, 1'b1, 1'b0};
    logic [18:0] ex[3] = '{{16'h0000, 3'b101}, {16'h0000, 3'b101}, {16'h8000, 3'b010}};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run16(xs[i], ys[i], 1'b0, cs[i], lat, bc);
      tests++;
      if ({b16.S, b16.carryout, b16.overflow, b16.zero} !== ex[i] || lat != 4) begin
        fails++;
        $display("FAIL wrap_%0d: got S=%h cvz=%b%b%b lat=%0d, want S=%h cvz=%b lat=4", i,
                 b16.S, b16.carryout, b16.overflow, b16.zero, lat, ex[i][18:3], ex[i][2:0]);
      end
      tick;
    end
  endtask

  task automatic test_subtract;
    logic [15:0] xs[4] = '{16'h0005, 16'h0005, 16'h8000, 16'h8000};
    logic [15:0] ys[4] = '{16'h0007, 16'h0007, 16'h0001, 16'h0001};
    logic        cs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [18:0] ex[4] = '{{16'hFFFE, 3'b000}, {16'hFFFE, 3'b000},
                           {16'h7FFF, 3'b110}, {16'h7FFF, 3'b110}};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run16(xs[i], ys[i], 1'b1, cs[i], lat, bc);
      tests++;
      if ({b16.S, b16.carryout, b16.overflow, b16.zero} !== ex[i] || lat != 4) begin
        fails++;
        $display("FAIL sub_%0d: got S=%h cvz=%b%b%b lat=%0d, want S=%h cvz=%b lat=4", i,
                 b16.S, b16.carryout, b16.overflow, b16.zero, lat, ex[i][18:3], ex[i][2:0]);
      end
      tick;
    end
  endtask

  task automatic test_reset_abort;
    int pulses = 0;
    drive16(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    tick;
    b16.start = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    tests++;
    if ({b16.busy, b16.done, b16.S, b16.carryout, b16.overflow, b16.zero} !== 21'h0) begin
      fails++;
      $display("FAIL abort_clear: busy=%b done=%b S=%h c=%b v=%b z=%b, want all 0",
               b16.busy, b16.done, b16.S, b16.carryout, b16.overflow, b16.zero);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (b16.done === 1'b1 || b16.busy === 1'b1) pulses++;
      tick;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d busy/done cycles, want 0", pulses);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bc;
    drive16(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
    tick;
    drive16(16'h0100, 16'h0200, 1'b1, 1'b1, 1'b1);
    tick;
    b16.start = 1'b0;
    wait16(lat, bc);
    tests++;
    if ({b16.S, b16.carryout, b16.overflow, b16.zero} !== {16'h0003, 3'b000} || lat != 3) begin
      fails++;
      $display("FAIL ignore_start: got S=%h cvz=%b%b%b lat=%0d, want S=0003 cvz=000 lat=3",
               b16.S, b16.carryout, b16.overflow, b16.zero, lat);
    end
    tick;
    tests++;
    if (b16.busy !== 1'b0 || b16.done !== 1'b0) begin
      fails++;
      $display("FAIL ignore_not_queued: got busy=%b done=%b, want 0 0", b16.busy, b16.done);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    int n = 0;
    logic stable = 1'b1;
    drive16(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    tick;
    wait16(lat, bc);
    tests++;
    if (b16.S !== 16'h3333 || lat != 4) begin
      fails++;
      $display("FAIL b2b_first: got S=%h lat=%0d, want S=3333 lat=4", b16.S, lat);
    end
    drive16(16'h00F0, 16'h0F10, 1'b0, 1'b0, 1'b1);
    tick;
    tests++;
    if (b16.busy !== 1'b1 || b16.done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_restart: got busy=%b done=%b, want 1 0", b16.busy, b16.done);
    end
    while (b16.done !== 1'b1 && n < 20) begin
      if (b16.S !== 16'h3333) stable = 1'b0;
      tick;
      n++;
    end
    b16.start = 1'b0;
    tests++;
    if (!stable || n != 4) begin
      fails++;
      $display("FAIL b2b_stable: got stable=%b period=%0d, want stable=1 period=4", stable, n);
    end
    tests++;
    if ({b16.S, b16.carryout, b16.overflow, b16.zero} !== {16'h1000, 3'b000}) begin
      fails++;
      $display("FAIL b2b_second: got S=%h cvz=%b%b%b, want S=1000 cvz=000",
               b16.S, b16.carryout, b16.overflow, b16.zero);
    end
    tick;
  endtask

  task automatic test_sweep8;
    logic [7:0] x, y, ye, es;
    logic       sb, ci;
    logic [8:0] full;
    logic       ev, ez;
    int         lat;
    for (int i = 0; i < 12; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      sb = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      if (i == 0) begin x = 8'h7F; y = 8'h01; sb = 1'b0; ci = 1'b0; end
      ye = sb ? ~y : y;
      full = {1'b0, x} + {1'b0, ye} + {8'h0, (sb | ci)};
      es = full[7:0];
      ev = (x[7] == ye[7]) && (es[7] != x[7]);
      ez = (es == 8'h0);
      b8.Xin = x; b8.Yin = y; b8.sub = sb; b8.carryin = ci; b8.start = 1'b1;
      tick;
      b8.start = 1'b0;
      lat = 0;
      while (b8.done !== 1'b1 && lat < 20) begin
        tick;
        lat++;
      end
      tests++;
      if ({b8.S, b8.carryout, b8.overflow, b8.zero} !== {es, full[8], ev, ez} || lat != 1) begin
        fails++;
        $display("FAIL sweep8_%0d: x=%h y=%h sub=%b ci=%b got S=%h cvz=%b%b%b lat=%0d, want S=%h cvz=%b%b%b lat=1",
                 i, x, y, sb, ci, b8.S, b8.carryout, b8.overflow, b8.zero, lat,
                 es, full[8], ev, ez);
      end
      tick;
    end
  endtask

  task automatic test_sweep32;
    logic [31:0] x, y, ye, es;
    logic        sb, ci;
    logic [32:0] full;
    logic        ev, ez;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      x = $urandom; y = $urandom;
      sb = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      if (i == 0) begin x = 32'h8000_0000; y = 32'h0000_0001; sb = 1'b1; ci = 1'b0; end
      if (i == 1) begin x = 32'h1234_5678; y = 32'h1234_5678; sb = 1'b1; ci = 1'b0; end
      ye = sb ? ~y : y;
      full = {1'b0, x} + {1'b0, ye} + {32'h0, (sb | ci)};
      es = full[31:0];
      ev = (x[31] == ye[31]) && (es[31] != x[31]);
      ez = (es == 32'h0);
      b32.Xin = x; b32.Yin = y; b32.sub = sb; b32.carryin = ci; b32.start = 1'b1;
      tick;
      b32.start = 1'b0;
      lat = 0;
      while (b32.done !== 1'b1 && lat < 20) begin
        tick;
        lat++;
      end
      tests++;
      if ({b32.S, b32.carryout, b32.overflow, b32.zero} !== {es, full[32], ev, ez} || lat != 4) begin
        fails++;
        $display("FAIL sweep32_%0d: x=%h y=%h sub=%b ci=%b got S=%h cvz=%b%b%b lat=%0d, want S=%h cvz=%b%b%b lat=4",
                 i, x, y, sb, ci, b32.S, b32.carryout, b32.overflow, b32.zero, lat,
                 es, full[32], ev, ez);
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_wrap;
    test_subtract;
    test_reset_abort;
    test_ignore_start;
    test_back_to_back;
    test_sweep8;
    test_sweep32;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end
endmodule
